// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order instruction buffer and
// redirect flush with stale-response drain. Define IFU_MISALIGN_EN to reject misaligned redirects.
module fetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i,
    input  logic              redirect_i,
`ifdef IFU_MISALIGN_EN
    output logic              misalign_o,
`endif
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q [FIFO_DEPTH];
    logic [31:0]       data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] dpc_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0] dpc_d  [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_d  [FIFO_DEPTH];

    logic              redir_take;
    logic [ADDR_W-1:0] redir_pc;
    logic              pop;
    logic              grant;
    logic              resp_acc;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  outst_nxt;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  tag_idx;

`ifdef IFU_MISALIGN_EN
    logic misalign_q;
    assign redir_take = redirect_i && (redirect_pc_i[1:0] == 2'b00);
    assign redir_pc   = redirect_pc_i;
`else
    logic [1:0] unused_pc_lsb;
    assign unused_pc_lsb = redirect_pc_i[1:0];
    assign redir_take    = redirect_i;
    assign redir_pc      = {redirect_pc_i[ADDR_W-1:2], 2'b00};
`endif

    // Credits count the word leaving decode this cycle so a depth-2 buffer sustains 1 instr/cycle
    assign pop        = valid_q && instr_ready_i;
    assign occ        = OCC_W'(outst_q) + OCC_W'(count_q) - OCC_W'(pop);
    assign imem_req_o = (state_q == RUN) && (occ < OCC_W'(FIFO_DEPTH));
    assign grant      = imem_req_o && imem_gnt_i;
    assign resp_acc   = (state_q == RUN) && imem_rvalid_i && (outst_q != '0);
    assign outst_nxt  = outst_q + CNT_W'(grant) - CNT_W'(resp_acc);
    assign push_idx   = IDX_W'(count_q - CNT_W'(pop));
    assign tag_idx    = IDX_W'(outst_q - CNT_W'(resp_acc));

    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = data_q[0];
    assign instr_pc_o    = dpc_q[0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        count_d    = count_q + CNT_W'(resp_acc) - CNT_W'(pop);
        data_d     = data_q;
        dpc_d      = dpc_q;
        tag_d      = tag_q;

        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                outst_d = outst_nxt;
                if (grant) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                end
                if (redir_take) begin
                    fetch_pc_d = redir_pc;
                    outst_d    = '0;
                    discard_d  = outst_nxt;
                    if (outst_nxt != '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (imem_rvalid_i && (discard_q != '0)) begin
                    discard_d = discard_q - CNT_W'(1);
                    if (discard_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                if (redir_take) begin
                    fetch_pc_d = redir_pc;
                end
            end
            default: state_d = BOOT;
        endcase

        // Tag FIFO: PCs of granted requests, head matches the next response
        if (resp_acc) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                tag_d[IDX_W'(i)] = tag_q[IDX_W'(i + 1)];
            end
        end
        if (grant && !redir_take) begin
            tag_d[tag_idx] = fetch_pc_q;
        end

        // Instruction buffer: entry 0 is the presented word
        if (pop) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                data_d[IDX_W'(i)] = data_q[IDX_W'(i + 1)];
                dpc_d[IDX_W'(i)]  = dpc_q[IDX_W'(i + 1)];
            end
        end
        if (resp_acc) begin
            data_d[push_idx] = imem_rdata_i;
            dpc_d[push_idx]  = tag_q[0];
        end
        if (redir_take && (state_q != BOOT)) begin
            count_d = '0;
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[IDX_W'(i)] <= '0;
                dpc_q[IDX_W'(i)]  <= '0;
                tag_q[IDX_W'(i)]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            dpc_q      <= dpc_d;
            tag_q      <= tag_d;
        end
    end

`ifdef IFU_MISALIGN_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00) && (state_q != BOOT);
        end
    end
    assign misalign_o = misalign_q;
`endif

endmodule
